// File: rtl/alu_pkg.sv
// Shared types and decode helpers for the sequential ALU with optional RV32M support.
// Op codes, FSM states and op-class predicates used by seq_alu_md and muldiv_iter.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLA    = 5'd3,
    OP_SRL    = 5'd4,
    OP_SRA    = 5'd5,
    OP_XOR    = 5'd6,
    OP_OR     = 5'd7,
    OP_AND    = 5'd8,
    OP_BEQ    = 5'd9,
    OP_BNE    = 5'd10,
    OP_BLT    = 5'd11,
    OP_BGE    = 5'd12,
    OP_SLT    = 5'd13,
    OP_SLTU   = 5'd14,
    OP_BLTU   = 5'd15,
    OP_BGEU   = 5'd16,
    OP_MUL    = 5'd17,
    OP_MULH   = 5'd18,
    OP_MULHSU = 5'd19,
    OP_MULHU  = 5'd20,
    OP_DIV    = 5'd21,
    OP_DIVU   = 5'd22,
    OP_REM    = 5'd23,
    OP_REMU   = 5'd24
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_branch(input logic [4:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_quotient(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/seq_alu_md_muldiv_iter.sv
// Iterative WIDTH-step multiplier (shift-add) and restoring divider on operand magnitudes,
// with the sign fix applied on the final step. Only instantiated when ALU_MULDIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam logic [SHW-1:0] LP_LAST = SHW'(WIDTH - 1);

  logic               w_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;

  logic               r_busy, r_is_div, r_sel_hi, r_neg;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH:0]     w_sum, w_trial;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod_fix;
  logic [WIDTH-1:0]   w_half;

  assign w_div      = is_div(i_op);
  assign w_a_signed = is_signed_div(i_op) || (i_op == OP_MULH) || (i_op == OP_MULHSU);
  assign w_b_signed = is_signed_div(i_op) || (i_op == OP_MULH);
  assign w_a_neg    = w_a_signed & i_a[WIDTH-1];
  assign w_b_neg    = w_b_signed & i_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_b_mag    = w_b_neg ? (~i_b + 1'b1) : i_b;

  // r_acc is {high product, multiplier} for multiply and {remainder, quotient} for divide.
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};

  assign w_acc_nxt = !r_is_div ? {w_sum, r_acc[WIDTH-1:1]}
                   : w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                   : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // The result is taken from the value the last iteration produces, so it is ready on the
  // same edge that completes the WIDTH-th step.
  assign w_prod_fix = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_half     = r_sel_hi ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
  assign o_result   = r_is_div ? (r_neg ? (~w_half + 1'b1) : w_half)
                    : (r_sel_hi ? w_prod_fix[2*WIDTH-1:WIDTH] : w_prod_fix[WIDTH-1:0]);
  assign o_done     = r_busy && (r_cnt == LP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_sel_hi <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_b      <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_is_div <= w_div;
      r_sel_hi <= i_op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
      r_neg    <= (i_op inside {OP_REM, OP_REMU}) ? w_a_neg : (w_a_neg ^ w_b_neg);
      r_b      <= w_div ? w_b_mag : w_a_mag;
      r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu_md.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes; base ops finish in one cycle.
// Define ALU_MULDIV_EN to build the iterative RV32M multiply/divide path (else ops 17-24 are illegal).
module seq_alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             illegal_op
);

  alu_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_branch, r_illegal;

  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_eq, w_ltu, w_lt, w_ovf;
  logic [WIDTH-1:0] w_fast_result;
  logic             w_fast_branch, w_fast_illegal;

`ifdef ALU_MULDIV_EN
  logic             w_needs_calc, w_start, w_md_done, w_div_ovf;
  logic [WIDTH-1:0] w_md_result;
`endif

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign result       = r_result;
  assign branch_taken = r_branch;
  assign illegal_op   = r_illegal;
  assign w_accept     = in_valid && in_ready;

  // Compares come from one subtractor: bit WIDTH is the borrow, signed-lt is sign XOR overflow.
  assign w_sum  = rs1 + rs2;
  assign w_diff = {1'b0, rs1} - {1'b0, rs2};
  assign w_eq   = (rs1 == rs2);
  assign w_ltu  = w_diff[WIDTH];
  assign w_ovf  = (rs1[WIDTH-1] ^ rs2[WIDTH-1]) & (w_diff[WIDTH-1] ^ rs1[WIDTH-1]);
  assign w_lt   = w_diff[WIDTH-1] ^ w_ovf;

`ifdef ALU_MULDIV_EN
  assign w_div_ovf = (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&rs2);
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_fast_result  = '0;
    w_fast_branch  = 1'b0;
    w_fast_illegal = 1'b0;
`ifdef ALU_MULDIV_EN
    w_needs_calc   = 1'b0;
`endif
    case (op)
      OP_ADD:         w_fast_result = w_sum;
      OP_SUB:         w_fast_result = w_diff[WIDTH-1:0];
      OP_SLL, OP_SLA: w_fast_result = rs1 << shamt;
      OP_SRL:         w_fast_result = rs1 >> shamt;
      OP_SRA:         w_fast_result = $signed(rs1) >>> shamt;
      OP_XOR:         w_fast_result = rs1 ^ rs2;
      OP_OR:          w_fast_result = rs1 | rs2;
      OP_AND:         w_fast_result = rs1 & rs2;
      OP_BEQ:         w_fast_branch = w_eq;
      OP_BNE:         w_fast_branch = !w_eq;
      OP_BLT:         w_fast_branch = w_lt;
      OP_BGE:         w_fast_branch = !w_lt;
      OP_BLTU:        w_fast_branch = w_ltu;
      OP_BGEU:        w_fast_branch = !w_ltu;
      OP_SLT:         w_fast_result = {{(WIDTH-1){1'b0}}, w_lt};
      OP_SLTU:        w_fast_result = {{(WIDTH-1){1'b0}}, w_ltu};
      default: begin
`ifdef ALU_MULDIV_EN
        if (is_muldiv(op)) begin
          // Divide-by-zero and signed overflow have fixed answers and skip the iteration.
          if (is_div(op) && (rs2 == '0))
            w_fast_result = is_quotient(op) ? '1 : rs1;
          else if (is_signed_div(op) && w_div_ovf)
            w_fast_result = is_quotient(op) ? rs1 : '0;
          else
            w_needs_calc = 1'b1;
        end else
`endif
        w_fast_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef ALU_MULDIV_EN
    w_start     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MULDIV_EN
          if (w_needs_calc) begin
            w_state_nxt = CALC;
            w_start     = 1'b1;
          end else
`endif
          w_state_nxt = DONE;
        end
      end
`ifdef ALU_MULDIV_EN
      CALC: if (w_md_done) w_state_nxt = DONE;
`endif
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept && (w_state_nxt == DONE)) begin
      r_result  <= w_fast_result;
      r_branch  <= w_fast_branch;
      r_illegal <= w_fast_illegal;
    end
`ifdef ALU_MULDIV_EN
    else if ((r_state == CALC) && w_md_done) begin
      r_result  <= w_md_result;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end
`endif
  end

`ifdef ALU_MULDIV_EN
  muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_op     (op),
    .i_a      (rs1),
    .i_b      (rs2),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );
`endif

endmodule

// File: tb/tb_seq_alu_md.sv
// Self-checking bench for seq_alu_md: directed cases plus random ops against an arithmetic model.
// Expectations for ops 17-24 follow ALU_MULDIV_EN the same way the design build does.
module tb_seq_alu_md;

  localparam int W = 32;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, branch_taken, illegal_op;
  logic [4:0]    op, shamt;
  logic [W-1:0]  rs1, rs2, result;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu_md #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .rs1          (rs1),
    .rs2          (rs2),
    .shamt        (shamt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the RISC-V definitions.
  function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] res,
                                output logic br, output logic ill, output int lat);
    int          sa, sb;
    logic [63:0] p;
    sa  = a;
    sb  = b;
    res = '0;
    br  = 1'b0;
    ill = 1'b0;
    lat = 1;
    p   = '0;
    case (o)
      5'd0:        res = a + b;
      5'd1:        res = a - b;
      5'd2, 5'd3:  res = a << sh;
      5'd4:        res = a >> sh;
      5'd5:        res = sa >>> sh;
      5'd6:        res = a ^ b;
      5'd7:        res = a | b;
      5'd8:        res = a & b;
      5'd9:        br  = (a == b);
      5'd10:       br  = (a != b);
      5'd11:       br  = (sa < sb);
      5'd12:       br  = (sa >= sb);
      5'd13:       res = {31'b0, (sa < sb)};
      5'd14:       res = {31'b0, (a < b)};
      5'd15:       br  = (a < b);
      5'd16:       br  = (a >= b);
`ifdef ALU_MULDIV_EN
      5'd17: begin res = a * b; lat = 33; end
      5'd18: begin p = longint'(sa) * longint'(sb); res = p[63:32]; lat = 33; end
      5'd19: begin p = longint'(sa) * longint'({32'b0, b}); res = p[63:32]; lat = 33; end
      5'd20: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; lat = 33; end
      5'd21, 5'd23: begin
        if (b == 0)                                res = (o == 5'd21) ? 32'hFFFF_FFFF : a;
        else if (a == 32'h8000_0000 && sb == -1)   res = (o == 5'd21) ? a : 32'h0;
        else begin
          res = (o == 5'd21) ? (sa / sb) : (sa % sb);
          lat = 33;
        end
      end
      5'd22, 5'd24: begin
        if (b == 0) res = (o == 5'd22) ? 32'hFFFF_FFFF : a;
        else begin
          res = (o == 5'd22) ? (a / b) : (a % b);
          lat = 33;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request with out_ready high, measure edges to out_valid, check outputs.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input string tag);
    logic [31:0] e_res;
    logic        e_br, e_ill;
    int          e_lat, lat;
    model(o, a, b, sh, e_res, e_br, e_ill, e_lat);
    @(negedge clk);
    check({tag, ".in_ready_pre"}, {31'b0, in_ready}, 32'h1);
    in_valid  = 1'b1;
    op        = o;
    rs1       = a;
    rs2       = b;
    shamt     = sh;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(e_lat));
    check({tag, ".result"}, result, e_res);
    check({tag, ".branch"}, {31'b0, branch_taken}, {31'b0, e_br});
    check({tag, ".illegal"}, {31'b0, illegal_op}, {31'b0, e_ill});
    check({tag, ".in_ready_busy"}, {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    check({tag, ".consumed"}, {30'b0, out_valid, in_ready}, 32'h1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    rs1       = '0;
    rs2       = '0;
    shamt     = '0;
    repeat (2) @(negedge clk);
    check("reset.out_valid", {31'b0, out_valid}, 32'h0);
    check("reset.result", result, 32'h0);
    check("reset.flags", {30'b0, branch_taken, illegal_op}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("reset.in_ready", {31'b0, in_ready}, 32'h1);

    // Directed cases from the plan.
    run_op(5'd0,  32'h7FFF_FFFF, 32'h1, 5'd0, "add_ovf");
    check("add_ovf.const", result, 32'h8000_0000);
    run_op(5'd11, 32'h8000_0000, 32'h1, 5'd0, "blt_neg");
    check("blt_neg.const", {31'b0, branch_taken}, 32'h1);
    run_op(5'd15, 32'h8000_0000, 32'h1, 5'd0, "bltu");
    run_op(5'd12, 32'd5,         32'd5, 5'd0, "bge_eq");
    run_op(5'd5,  32'h8000_00F0, 32'h0, 5'd4, "sra");
    run_op(5'd13, 32'hFFFF_FFFF, 32'h0, 5'd0, "slt");
    run_op(5'd14, 32'hFFFF_FFFF, 32'h0, 5'd0, "sltu");
    run_op(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "mulh");
    run_op(5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "mulhu");
    run_op(5'd17, 32'd7,         32'hFFFF_FFFD, 5'd0, "mul");
    run_op(5'd19, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd0, "mulhsu");
    run_op(5'd21, 32'hFFFF_FFF9, 32'd2, 5'd0, "div_neg");
    run_op(5'd23, 32'hFFFF_FFF9, 32'd2, 5'd0, "rem_neg");
    run_op(5'd22, 32'h1234_5678, 32'd0, 5'd0, "divu_zero");
    run_op(5'd24, 32'h1234_5678, 32'd0, 5'd0, "remu_zero");
    run_op(5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, "div_ovf");
    run_op(5'd23, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, "rem_ovf");
    run_op(5'd27, 32'h1,         32'h2, 5'd0, "illegal27");

    // Backpressure: result held, second request ignored while busy.
    @(negedge clk);
    in_valid  = 1'b1;
    op        = 5'd1;
    rs1       = 32'd3;
    rs2       = 32'd5;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.hold%0d", i), {30'b0, out_valid, in_ready}, 32'h2);
      check($sformatf("bp.result%0d", i), result, 32'hFFFF_FFFE);
      if (i == 1) begin
        in_valid = 1'b1;
        op       = 5'd0;
        rs1      = 32'd1;
        rs2      = 32'd1;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.released", {30'b0, out_valid, in_ready}, 32'h1);
    @(negedge clk);
    check("bp.no_ghost", {30'b0, out_valid, in_ready}, 32'h1);

    // Reset while the long divide (or the held result in a base-only build) is pending.
    in_valid  = 1'b1;
    op        = 5'd22;
    rs1       = $urandom;
    rs2       = 32'd3;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.out_valid", {31'b0, out_valid}, 32'h0);
    check("abort.result", result, 32'h0);
    check("abort.flags", {30'b0, branch_taken, illegal_op}, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("abort.in_ready", {31'b0, in_ready}, 32'h1);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort.no_stale", 32'(seen), 32'h0);
    end

    // Random ops against the model.
    for (int k = 0; k < 60; k++) begin
      logic [4:0] ro;
      ro = 5'($urandom_range(0, 31));
      run_op(ro, pick(), pick(), 5'($urandom), $sformatf("rnd%0d_op%0d", k, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu_md.md
Name: seq_alu_md

Overview:
Multi-cycle, parametrised successor to the combinational core ALU for the multi-cycle RISC-V core. It adds RV32M multiply/divide through an iterative shift-add / restoring-divide datapath, unsigned compares/branches, and a valid/ready handshake on input and output. Base ops complete in 1 cycle; MUL*/DIV*/REM* take WIDTH cycles. The block sits in the execute stage and is sequenced by the core control FSM.

Parameters:
WIDTH, 32, operand/result width (power of 2, ≥8)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept request
op  in  5  operation code (alu_pkg::alu_op_e)
rs1  in  WIDTH  operand A / dividend / multiplicand
rs2  in  WIDTH  operand B / divisor / multiplier
shamt  in  SHW  shift amount
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
branch_taken  out  1  registered branch decision (branch ops only, else 0)
illegal_op  out  1  registered; op not supported

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. On rst: state=IDLE; out_valid, result, branch_taken, illegal_op=0; in_ready=1 after release.
- Op codes: ADD 0, SUB 1, SLL 2, SLA 3 (=SLL), SRL 4, SRA 5, XOR 6, OR 7, AND 8, BEQ 9, BNE 10, BLT 11, BGE 12, SLT 13, SLTU 14, BLTU 15, BGEU 16, MUL 17, MULH 18, MULHSU 19, MULHU 20, DIV 21, DIVU 22, REM 23, REMU 24. Codes 25-31 are illegal.
- in_ready = (state==IDLE). A request is accepted on the clk edge where in_valid && in_ready; operands and op are captured.
- FSM:
  - IDLE → DONE for base, illegal, and special-case div ops (latency 1: out_valid rises on the edge after accept).
  - IDLE → CALC for mul/div. CALC runs exactly WIDTH iterations, then → DONE (latency WIDTH+1).
  - DONE holds result, branch_taken, illegal_op and out_valid stable until out_valid && out_ready, then → IDLE.
  - A request cannot be accepted in the same cycle a result is consumed.
- Arithmetic: add/sub modulo 2^WIDTH. Signed compares are true two's-complement: BLT/SLT use (diff sign XOR overflow); BGE = !BLT. Unsigned compares use the carry-out. SLT/SLTU produce {0…,bit}. Branch ops put 0 on result.
- MUL returns low WIDTH bits. MULH/MULHSU/MULHU return high WIDTH bits of the 2·WIDTH product with the RISC-V signedness of each operand. Implemented as an unsigned magnitude iteration plus final sign correction.
- DIV/REM truncate toward zero; the remainder takes the dividend's sign.
- Divide by zero: quotient = all ones, remainder = rs1. Signed overflow (rs1 = most-negative, rs2 = -1): quotient = rs1, remainder = 0. Both cases take 1 cycle, with no CALC.
- Illegal op: result=0, branch_taken=0, illegal_op=1, latency 1.
- rst asserted mid-CALC or in DONE aborts immediately to reset values; no stale result appears after release.
- in_valid while busy is ignored; the upstream holds its request.

Optional Feature:
ALU_MULDIV_EN. Defined: mul/div ops are supported as above. Undefined: the iterative datapath is not built; op codes 17-24 are treated as illegal (1-cycle, result=0, illegal_op=1) and the CALC state does not exist.

Decomposition:
- Package alu_pkg: alu_op_e enum (5-bit), alu_state_e {IDLE, CALC, DONE}, and helper functions is_branch(op), is_muldiv(op), is_signed_div(op).
- One sub-module, muldiv_iter. It has start, signed-control bits, a WIDTH-step counter, a 2·WIDTH product/remainder register, and a done pulse, and is instantiated only under ALU_MULDIV_EN. Base ops stay inline in seq_alu_md.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1, out_ready=1 → out_valid 1 cycle after accept, result=0x80000000, in_ready back next cycle.
- BLT rs1=0x80000000, rs2=1 → branch_taken=1, result=0; BLTU same operands → branch_taken=0; BGE 5,5 → 1.
- MULH rs1=0xFFFFFFFF(-1), rs2=0xFFFFFFFF → result=0 after 33 cycles. MULHU same operands → 0xFFFFFFFE. MUL 7×-3 → 0xFFFFFFEB.
- DIV -7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU x/0 → 0xFFFFFFFF in 1 cycle. DIV 0x80000000/-1 → 0x80000000, REM → 0.
- Backpressure: out_ready=0 for 5 cycles after SUB 3-5 → result held at 0xFFFFFFFE, in_ready=0, a second in_valid is ignored; then out_ready=1 → IDLE.
- rst pulsed at CALC iteration 10 of DIVU → out_valid=0, result=0, in_ready=1 after release. Op 27, and op 17 with ALU_MULDIV_EN undefined → illegal_op=1, result=0.
